// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per cycle.
// Signed (two's-complement) support is compiled in only when DIV_SEQ_SIGNED_EN is defined;
// otherwise i_signed is ignored and every operand is treated as unsigned.
module div_seq #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remain,
    output logic             o_dbz,
    output logic             o_ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, OPERATE, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             q_neg;
    logic             r_neg;
    logic             ovf_pend;
    logic             sg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             ovf_case;
    logic             unused_bits;

`ifdef DIV_SEQ_SIGNED_EN
    assign sg = i_signed;
`else
    assign sg = 1'b0;
`endif

    // The partial remainder never exceeds the divisor after a step, so its top bit is only
    // meaningful inside the trial subtraction.
    assign unused_bits = ^{rem[WIDTH], i_signed};

    assign a_abs    = (sg && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
    assign b_abs    = (sg && i_divisor[WIDTH-1]) ? -i_divisor : i_divisor;
    assign shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs};
    assign ovf_case = sg && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&i_divisor);

    // Control FSM and datapath: accept, WIDTH restoring steps, sign fix-up, one-cycle done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            ovf_pend   <= 1'b0;
            o_ready    <= 1'b1;
            o_done     <= 1'b0;
            o_quotient <= '0;
            o_remain   <= '0;
            o_dbz      <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    o_ready    <= 1'b0;
                    o_quotient <= '0;
                    o_remain   <= '0;
                    o_dbz      <= 1'b0;
                    o_ovf      <= 1'b0;
                    cnt        <= '0;
                    if (i_divisor == '0) begin
                        state      <= DONE;
                        o_done     <= 1'b1;
                        o_dbz      <= 1'b1;
                        o_quotient <= '1;
                        o_remain   <= i_dividend;
                    end else begin
                        state    <= OPERATE;
                        rem      <= '0;
                        quo      <= a_abs;
                        dvs      <= b_abs;
                        q_neg    <= sg && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
                        r_neg    <= sg && i_dividend[WIDTH-1];
                        ovf_pend <= ovf_case;
                    end
                end
                OPERATE: if (cnt == LAST) begin
                    state <= FIX;
                end else begin
                    cnt <= cnt + 1'b1;
                    rem <= trial[WIDTH] ? shifted : trial;
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                end
                FIX: begin
                    o_quotient <= q_neg ? -quo : quo;
                    o_remain   <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    o_ovf      <= ovf_pend;
                    o_done     <= 1'b1;
                    state      <= DONE;
                end
                default: begin
                    o_done  <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vector bench for div_seq (WIDTH=8 and WIDTH=16 instances);
// signed expectations follow DIV_SEQ_SIGNED_EN.
module tb_div_seq;
`ifdef DIV_SEQ_SIGNED_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st8, sg8, rdy8, d8, dbz8, ovf8;
    logic [7:0]  a8, b8, q8, r8;
    logic        st16, sg16, rdy16, d16, dbz16, ovf16;
    logic [15:0] a16, b16, q16, r16;

    int checks = 0;
    int errors = 0;

    div_seq #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st8), .i_signed(sg8),
        .i_dividend(a8), .i_divisor(b8), .o_ready(rdy8), .o_done(d8),
        .o_quotient(q8), .o_remain(r8), .o_dbz(dbz8), .o_ovf(ovf8)
    );

    div_seq #(.WIDTH(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st16), .i_signed(sg16),
        .i_dividend(a16), .i_divisor(b16), .o_ready(rdy16), .o_done(d16),
        .o_quotient(q16), .o_remain(r16), .o_dbz(dbz16), .o_ovf(ovf16)
    );

    typedef struct {
        bit         s;
        logic [7:0] a, b, q, r;
        bit         dbz, ovf;
    } vec_t;

    vec_t v[12];
    logic [15:0] eq16[3];
    logic [15:0] er16[3];
    logic [15:0] na16[2];
    logic [15:0] nb16[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [7:0] r,
                        input bit dbz, input bit ovf, input string tag);
        int n;
        @(negedge clk);
        chk({tag, "_ready"}, rdy8, 1);
        st8 = 1'b1; sg8 = s; a8 = a; b8 = b;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        if (!dbz) begin
            chk({tag, "_clear"}, {q8, r8, dbz8, ovf8}, 0);
            chk({tag, "_busy"}, rdy8, 0);
        end
        n = 0;
        while (!d8 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n, dbz ? 0 : 10);
        chk({tag, "_quot"}, q8, q);
        chk({tag, "_rem"}, r8, r);
        chk({tag, "_dbz"}, dbz8, dbz);
        chk({tag, "_ovf"}, ovf8, ovf);
        @(posedge clk);
        #1;
        chk({tag, "_after"}, {d8, rdy8, q8, r8}, {1'b0, 1'b1, q, r});
    endtask

    initial begin
        int n;
        v[0]  = '{1'b0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0};
        v[1]  = '{1'b1, 8'hF9,  8'd2,   SE ? 8'hFD : 8'h7C, SE ? 8'hFF : 8'h01, 1'b0, 1'b0};
        v[2]  = '{1'b1, 8'd7,   8'hFE,  SE ? 8'hFD : 8'h00, SE ? 8'h01 : 8'h07, 1'b0, 1'b0};
        v[3]  = '{1'b0, 8'd55,  8'd0,   8'hFF,  8'd55,  1'b1, 1'b0};
        v[4]  = '{1'b1, 8'h80,  8'hFF,  SE ? 8'h80 : 8'h00, SE ? 8'h00 : 8'h80, 1'b0, SE};
        v[5]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0};
        v[6]  = '{1'b0, 8'd3,   8'd200, 8'd0,   8'd3,   1'b0, 1'b0};
        v[7]  = '{1'b1, 8'h9C,  8'd7,   SE ? 8'hF2 : 8'h16, SE ? 8'hFE : 8'h02, 1'b0, 1'b0};
        v[8]  = '{1'b1, 8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1'b0};
        v[9]  = '{1'b1, 8'h80,  8'd1,   8'h80,  8'h00,  1'b0, 1'b0};
        v[10] = '{1'b0, 8'd200, 8'd10,  8'd20,  8'd0,   1'b0, 1'b0};
        v[11] = '{1'b1, 8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0, 1'b0};
        eq16 = '{16'd333, 16'd255, 16'd0};
        er16 = '{16'd1, 16'd255, 16'd0};
        na16 = '{16'd65535, 16'd0};
        nb16 = '{16'd256, 16'd9};

        rst_n = 1'b0;
        st8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
        st16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
        #12;
        chk("reset8", {rdy8, d8, q8, r8, dbz8, ovf8}, {1'b1, 1'b0, 18'd0});
        chk("reset16", {rdy16, d16, q16, r16, dbz16, ovf16}, {1'b1, 1'b0, 34'd0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run8(v[i].s, v[i].a, v[i].b, v[i].q, v[i].r, v[i].dbz, v[i].ovf, $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of OPERATE must abort without a done pulse.
        @(negedge clk);
        st8 = 1'b1; sg8 = 1'b0; a8 = 8'd100; b8 = 8'd7;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset", {rdy8, d8, q8, r8, dbz8, ovf8}, {1'b1, 1'b0, 18'd0});
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (d8) n++;
        end
        chk("midreset_nodone", n, 0);
        chk("midreset_idle", rdy8, 1);
        run8(1'b0, 8'd200, 8'd10, 8'd20, 8'd0, 1'b0, 1'b0, "post_reset");

        // WIDTH=16 back-to-back with i_start held high; operand changes while busy are ignored.
        @(negedge clk);
        st16 = 1'b1; a16 = 16'd1000; b16 = 16'd3;
        @(posedge clk);
        #1;
        chk("b2b_acc0", rdy16, 0);
        a16 = 16'hAAAA; b16 = 16'd0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!d16 && n < 60) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk($sformatf("b2b%0d_latency", k), n, 18);
            chk($sformatf("b2b%0d_quot", k), q16, eq16[k]);
            chk($sformatf("b2b%0d_rem", k), r16, er16[k]);
            chk($sformatf("b2b%0d_flags", k), {dbz16, ovf16}, 0);
            if (k == 2) st16 = 1'b0;
            else begin
                a16 = na16[k]; b16 = nb16[k];
            end
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_idle", k), {rdy16, d16}, 2'b10);
            if (k < 2) begin
                @(posedge clk);
                #1;
                chk($sformatf("b2b%0d_accept", k), {rdy16, q16, r16}, 0);
                a16 = 16'hAAAA; b16 = 16'd0;
            end
        end
        @(posedge clk);
        #1;
        chk("b2b_stop", {rdy16, d16}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
